// File: rtl/mem_sync_sp_arb.sv
// ---------------------------------------------------------------------------
// mem_sync_sp_arb : two-port arbiter onto one synchronous single-port SRAM
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_sync_sp_arb #(
  parameter int DEPTH      = 2048,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int DATA_WIDTH = 32,
  parameter int DATA_BYTES = DATA_WIDTH / 8,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_p0_req,
  input  logic [ADDR_WIDTH-1:0] i_p0_addr,
  input  logic [DATA_WIDTH-1:0] i_p0_wdata,
  input  logic [DATA_BYTES-1:0] i_p0_wen,
  output logic                  o_p0_gnt,
  output logic                  o_p0_rvalid,
  output logic [DATA_WIDTH-1:0] o_p0_rdata,
  input  logic                  i_p1_req,
  input  logic [ADDR_WIDTH-1:0] i_p1_addr,
  input  logic [DATA_WIDTH-1:0] i_p1_wdata,
  input  logic [DATA_BYTES-1:0] i_p1_wen,
  output logic                  o_p1_gnt,
  output logic                  o_p1_rvalid,
  output logic [DATA_WIDTH-1:0] o_p1_rdata,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic [DATA_BYTES-1:0] o_mem_wen,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  localparam int C_WAIT_W = $clog2(MAX_WAIT + 1);

  logic [C_WAIT_W-1:0]   r_wait_cnt;
  logic                  r_resp_v;
  logic                  r_resp_port;
  logic [ADDR_WIDTH-1:0] r_last_addr;
  logic                  w_force0;
  logic                  w_gnt0;
  logic                  w_gnt1;

  assign w_force0 = (r_wait_cnt == C_WAIT_W'(MAX_WAIT));

  // Grants are masked while reset is held so every output reads 0 in reset.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (rst_n) begin
      if (i_p1_req && !(i_p0_req && w_force0)) begin
        w_gnt1 = 1'b1;
      end else if (i_p0_req) begin
        w_gnt0 = 1'b1;
      end
    end
  end

  assign o_p0_gnt = w_gnt0;
  assign o_p1_gnt = w_gnt1;

  always_comb begin
    o_mem_addr  = r_last_addr;
    o_mem_wdata = '0;
    o_mem_wen   = '0;
    if (w_gnt1) begin
      o_mem_addr  = i_p1_addr;
      o_mem_wdata = i_p1_wdata;
      o_mem_wen   = i_p1_wen;
    end else if (w_gnt0) begin
      o_mem_addr  = i_p0_addr;
      o_mem_wdata = i_p0_wdata;
      o_mem_wen   = i_p0_wen;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt  <= '0;
      r_resp_v    <= 1'b0;
      r_resp_port <= 1'b0;
      r_last_addr <= '0;
    end else begin
      if (!i_p0_req || w_gnt0) begin
        r_wait_cnt <= '0;
      end else if (!w_force0) begin
        r_wait_cnt <= r_wait_cnt + C_WAIT_W'(1);
      end
      r_resp_v    <= w_gnt0 | w_gnt1;
      r_resp_port <= w_gnt1;
      if (w_gnt0 || w_gnt1) begin
        r_last_addr <= o_mem_addr;
      end
    end
  end

  assign o_p0_rvalid = r_resp_v && !r_resp_port;
  assign o_p1_rvalid = r_resp_v &&  r_resp_port;
  assign o_p0_rdata  = o_p0_rvalid ? i_mem_rdata : '0;
  assign o_p1_rdata  = o_p1_rvalid ? i_mem_rdata : '0;

endmodule

`default_nettype wire

// File: doc/mem_sync_sp_arb.md
Name: mem_sync_sp_arb

Overview:
- Two-requester arbiter that shares one synchronous single-port SRAM word memory (byte write enables, 1-cycle read latency) between port 0 (instruction fetch) and port 1 (load/store).
- Sits between the core's fetch/LSU request ports and the memory's addr/wdata/wen/rdata interface.
- Grants at most one access per cycle. Port 1 has priority by default; a starvation counter forces a port-0 grant.
- Routes each read response back to the port that issued it.

Parameters:
- DEPTH, 2048, memory depth in words
- ADDR_WIDTH, $clog2(DEPTH), word address width
- DATA_WIDTH, 32, word width (32 or 64)
- DATA_BYTES, DATA_WIDTH/8, byte-enable width
- MAX_WAIT, 4, consecutive denied cycles of port 0 before it is forced to priority (1..15)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_p0_req  in  1  port 0 request
- i_p0_addr  in  ADDR_WIDTH  port 0 word address
- i_p0_wdata  in  DATA_WIDTH  port 0 write data
- i_p0_wen  in  DATA_BYTES  port 0 byte write enables (0 = read)
- o_p0_gnt  out  1  port 0 request accepted this cycle
- o_p0_rvalid  out  1  port 0 response valid
- o_p0_rdata  out  DATA_WIDTH  port 0 read data
- i_p1_req, i_p1_addr, i_p1_wdata, i_p1_wen, o_p1_gnt, o_p1_rvalid, o_p1_rdata: same as port 0, for port 1
- o_mem_addr  out  ADDR_WIDTH  to memory i_addr
- o_mem_wdata  out  DATA_WIDTH  to memory i_wdata
- o_mem_wen  out  DATA_BYTES  to memory i_wen
- i_mem_rdata  in  DATA_WIDTH  from memory o_rdata

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low on rst_n: assertion clears all state immediately; deassertion takes effect at the next clk edge.
- Handshake:
  - o_pX_gnt is combinational, in the same cycle as the request. A transfer occurs on req && gnt.
  - The requester holds req, addr, wdata and wen stable until it sees gnt.
  - gnt is never asserted without req. At most one gnt is asserted per cycle.
- Arbitration:
  - Port 1 wins when both ports request, unless force0 is set.
  - force0 = (wait_cnt == MAX_WAIT).
  - wait_cnt is a register of width $clog2(MAX_WAIT+1).
  - wait_cnt increments when i_p0_req && !o_p0_gnt, saturating at MAX_WAIT.
  - wait_cnt clears to 0 when o_p0_gnt, or when i_p0_req is low.
- Memory drive:
  - When a port is granted, o_mem_addr, o_mem_wdata and o_mem_wen are the granted port's inputs, combinationally.
  - With no grant: o_mem_wen = 0, o_mem_addr = last granted address (held in last_addr), o_mem_wdata = 0.
- Responses:
  - Every granted transfer, read or write, produces exactly one o_pX_rvalid pulse to the granting port, exactly 1 cycle after gnt.
  - o_pX_rdata = i_mem_rdata, passed through while o_pX_rvalid is high; it is 0 otherwise.
  - For writes, rdata content is unspecified and unchecked.
  - Response state is held in registers resp_v and resp_port, loaded every cycle.
- Back-to-back: a new grant is allowed in the same cycle as the previous response, giving full throughput of 1 access/cycle.
- Read-after-write to the same address in consecutive cycles returns the newly written bytes.
- Reset values:
  - All gnt outputs, rvalid outputs and rdata outputs are 0.
  - o_mem_wen = 0, o_mem_addr = 0, o_mem_wdata = 0.
  - wait_cnt = 0, resp_v = 0, last_addr = 0.
- Reset mid-operation: a pending response is dropped, with no rvalid after reset release. The first grant is possible in the first cycle after deassertion.
- A request with wen != 0 and partial byte enables writes only the enabled bytes (memory behaviour); the arbiter forwards wen unmodified.

Test Plan:
- p0 read addr 0x010 alone, memory preloaded with 0xDEADBEEF -> o_p0_gnt=1 same cycle; next cycle o_p0_rvalid=1 with o_p0_rdata=0xDEADBEEF; o_p1_rvalid stays 0.
- p0 and p1 both request reads in the same cycle (p0 0x004, p1 0x008) -> o_p1_gnt=1, o_p0_gnt=0; next cycle p1 response and p0 granted; p0 response the cycle after.
- p1 requests continuously for 10 cycles while p0 holds a request, MAX_WAIT=4 -> p0 denied 4 cycles, granted in cycle 5, p1 denied in that cycle; wait_cnt returns to 0.
- p1 writes 0x11223344 with wen=4'b0101 to 0x020 (old value 0xAAAAAAAA), then p1 reads 0x020 next cycle -> rdata=0xAA22AA44; two rvalid pulses, one per cycle.
- p0 read granted, then rst_n asserted before the response cycle -> no o_p0_rvalid; all outputs 0 during reset; read of the same address after release returns correct data.
- Idle cycles following a grant to 0x3FF -> o_mem_addr holds 0x3FF, o_mem_wen=0, no gnt or rvalid asserted.
